// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StRefill
    } state_e;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int unsigned offset_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned index_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Byte-in-word bits [1:0] are never part of the tag.
    function automatic int unsigned tag_w(input int unsigned sets, input int unsigned line_words);
        return 32 - offset_w(line_words) - index_w(sets) - 2;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: per-set valid bit, tag and line data, with combinational lookup.
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned INDEX_W    = index_w(SETS),
    parameter int unsigned OFFSET_W   = offset_w(LINE_WORDS),
    parameter int unsigned TAG_W      = tag_w(SETS, LINE_WORDS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    input  logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic                rd_match,
    output logic [31:0]         rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [31:0]         wr_data,
    input  logic                install,
    input  logic [TAG_W-1:0]    install_tag,
    input  logic                clear_all
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (install) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[wr_index] <= install_tag;
        end
        if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_match = rd_valid && (tag_q[rd_index] == rd_tag);
    assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with single-outstanding AXI line refill.
// IDLE lookups are combinational; a miss refills the victim way and then hits.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int unsigned SETS       = 64,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] addr,
    input  logic        addr_en,
    output logic [31:0] inst_o,
    output logic        hit,
    output logic        miss,
    output logic [31:0] axi_araddr,
    output logic [7:0]  axi_arlen,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic        axi_rvalid,
    input  logic        axi_rlast
);

    localparam int unsigned OFFSET_W  = offset_w(LINE_WORDS);
    localparam int unsigned INDEX_W   = index_w(SETS);
    localparam int unsigned TAG_W     = tag_w(SETS, LINE_WORDS);
    localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << (OFFSET_W + 2)) - 32'd1);

    if (!is_pow2(SETS) || SETS < 2) begin : g_bad_sets
        $error("icache_assoc: SETS must be a power of two >= 2");
    end
    if (!is_pow2(WAYS) || WAYS > 8) begin : g_bad_ways
        $error("icache_assoc: WAYS must be a power of two in 1..8");
    end
    if (!is_pow2(LINE_WORDS) || LINE_WORDS < 2 || LINE_WORDS > 16) begin : g_bad_line
        $error("icache_assoc: LINE_WORDS must be a power of two in 2..16");
    end

    state_e              state_q;
    logic                arvalid_q;
    logic [31:0]         araddr_q;
    logic [WAY_W-1:0]    victim_q;
    logic [OFFSET_W-1:0] beat_q;
    logic                abort_q;
    logic [WAY_W-1:0]    rr_q [SETS];

    logic [OFFSET_W-1:0] req_offset;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;
    logic                unused_addr_lsbs;

    logic [WAYS-1:0]     way_valid;
    logic [WAYS-1:0]     way_match;
    logic [31:0]         way_data [WAYS];
    logic [31:0]         hit_data;
    logic [WAY_W-1:0]    victim;
    logic                lookup_hit;
    logic                beat_we;
    logic                install;

    assign req_offset       = addr[OFFSET_W+1:2];
    assign req_index        = addr[OFFSET_W+2 +: INDEX_W];
    assign req_tag          = addr[31 -: TAG_W];
    assign fill_index       = araddr_q[OFFSET_W+2 +: INDEX_W];
    assign fill_tag         = araddr_q[31 -: TAG_W];
    assign unused_addr_lsbs = ^addr[1:0];

    assign beat_we = (state_q == StRefill) && axi_rvalid;
    // A flush landing on the last beat aborts the install just like an earlier one.
    assign install = beat_we && axi_rlast && !abort_q && !flush;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS)
        ) u_way (
            .clk         (clk),
            .resetn      (resetn),
            .rd_index    (req_index),
            .rd_offset   (req_offset),
            .rd_tag      (req_tag),
            .rd_valid    (way_valid[w]),
            .rd_match    (way_match[w]),
            .rd_data     (way_data[w]),
            .wr_en       (beat_we && (victim_q == WAY_W'(w))),
            .wr_index    (fill_index),
            .wr_offset   (beat_q),
            .wr_data     (axi_rdata),
            .install     (install && (victim_q == WAY_W'(w))),
            .install_tag (fill_tag),
            .clear_all   (flush)
        );
    end

    // Tags are unique within a set, so at most one way matches and OR-ing is a mux.
    always_comb begin
        hit_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (way_match[w]) begin
                hit_data = hit_data | way_data[w];
            end
        end
    end

    always_comb begin
        logic found;
        found  = 1'b0;
        victim = rr_q[req_index];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !way_valid[w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    assign lookup_hit = |way_match;

    // Outputs are gated by resetn so reset clears them without waiting for a clock.
    assign hit    = resetn && (state_q == StIdle) && addr_en && !flush && lookup_hit;
    assign miss   = resetn && addr_en && !hit;
    assign inst_o = hit ? hit_data : 32'd0;

    assign axi_araddr  = araddr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_arlen   = 8'(LINE_WORDS - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            victim_q  <= '0;
            beat_q    <= '0;
            abort_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (addr_en && !flush && !lookup_hit) begin
                        araddr_q  <= addr & LINE_MASK;
                        victim_q  <= victim;
                        arvalid_q <= 1'b1;
                        abort_q   <= 1'b0;
                        state_q   <= StAr;
                    end
                end
                StAr: begin
                    if (flush) begin
                        abort_q <= 1'b1;
                    end
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= StRefill;
                    end
                end
                StRefill: begin
                    if (flush) begin
                        abort_q <= 1'b1;
                    end
                    if (axi_rvalid) begin
                        beat_q <= beat_q + OFFSET_W'(1);
                        if (axi_rlast) begin
                            abort_q <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (install) begin
            rr_q[fill_index] <= (rr_q[fill_index] == WAY_W'(WAYS - 1)) ? '0
                                                                       : rr_q[fill_index] + WAY_W'(1);
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters; the bench plays the AXI read slave.
module tb_icache_assoc;

    localparam int          LW        = 8;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [31:0] addr;
    logic        addr_en;
    logic [31:0] inst_o;
    logic        hit;
    logic        miss;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic        axi_rvalid;
    logic        axi_rlast;

    int vectors    = 0;
    int miscompares = 0;

    icache_assoc dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .addr        (addr),
        .addr_en     (addr_en),
        .inst_o      (inst_o),
        .hit         (hit),
        .miss        (miss),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rvalid  (axi_rvalid),
        .axi_rlast   (axi_rlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {hit,miss} packed as 2=hit, 1=miss, 0=idle.
    function automatic logic [31:0] hm();
        return {30'd0, hit, miss};
    endfunction

    task automatic probe(input string tag, input logic [31:0] a, input bit exp_hit,
                         input logic [31:0] exp_inst);
        addr    = a;
        addr_en = 1'b1;
        #1;
        check(tag, hm(), exp_hit ? 32'd2 : 32'd1);
        if (exp_hit) check({tag, "_inst"}, inst_o, exp_inst);
        addr_en = 1'b0;
        tick;
    endtask

    // Miss on a, optional arready stall with stray beats, LW beats of dbase+k, optional flush.
    task automatic fill(input logic [31:0] a, input logic [31:0] dbase, input int ar_wait,
                        input int flush_beat);
        addr    = a;
        addr_en = 1'b1;
        #1;
        check("fill_miss", hm(), 32'd1);
        tick;
        check("ar_valid", {31'd0, axi_arvalid}, 32'd1);
        check("ar_addr", axi_araddr, a & LINE_MASK);
        check("ar_len", {24'd0, axi_arlen}, 32'd7);
        for (int i = 0; i < ar_wait; i++) begin
            axi_rvalid = 1'b1;
            axi_rdata  = 32'hDEAD_0000 + i;
            axi_rlast  = (i == ar_wait - 1);
            #1;
            check("ar_stall_valid", {31'd0, axi_arvalid}, 32'd1);
            check("ar_stall_addr", axi_araddr, a & LINE_MASK);
            check("ar_stall_miss", hm(), 32'd1);
            tick;
        end
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        axi_arready = 1'b1;
        tick;
        axi_arready = 1'b0;
        #1;
        check("ar_accepted", {31'd0, axi_arvalid}, 32'd0);
        for (int k = 0; k < LW; k++) begin
            flush      = (k == flush_beat);
            axi_rvalid = 1'b1;
            axi_rdata  = dbase + k;
            axi_rlast  = (k == LW - 1);
            #1;
            check("refill_miss", hm(), 32'd1);
            tick;
        end
        flush      = 1'b0;
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        #1;
        if (flush_beat < 0) begin
            check("fill_hit", hm(), 32'd2);
            check("fill_inst", inst_o, dbase + ((a >> 2) & 32'h7));
        end else begin
            check("aborted_fill_miss", hm(), 32'd1);
        end
        addr_en = 1'b0;
        tick;
    endtask

    initial begin
        resetn      = 1'b0;
        flush       = 1'b0;
        addr        = 32'h0000_0040;
        addr_en     = 1'b1;
        axi_arready = 1'b0;
        axi_rdata   = 32'd0;
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        #3;
        check("reset_hit_miss", hm(), 32'd0);
        check("reset_arvalid", {31'd0, axi_arvalid}, 32'd0);
        check("reset_araddr", axi_araddr, 32'd0);
        check("reset_inst", inst_o, 32'd0);
        addr_en = 1'b0;
        #9;
        resetn = 1'b1;
        tick;

        // Cold miss, then hits across the line.
        fill(32'h0000_0040, 32'h0000_0100, 0, -1);
        probe("word7", 32'h0000_005C, 1'b1, 32'h0000_0107);
        probe("word2", 32'h0000_0048, 1'b1, 32'h0000_0102);
        addr = 32'h0000_0040;
        #1;
        check("no_req_idle", hm(), 32'd0);
        tick;

        // Two ways in set 0, third tag evicts way 0 by round-robin.
        fill(32'h0000_0000, 32'h0000_0200, 0, -1);
        fill(32'h0000_0800, 32'h0000_0300, 0, -1);
        probe("assoc_w0", 32'h0000_0000, 1'b1, 32'h0000_0200);
        probe("assoc_w1", 32'h0000_0804, 1'b1, 32'h0000_0301);
        fill(32'h0000_1000, 32'h0000_0400, 0, -1);
        probe("evict_new", 32'h0000_1008, 1'b1, 32'h0000_0402);
        probe("evict_kept", 32'h0000_0800, 1'b1, 32'h0000_0300);
        probe("evict_gone", 32'h0000_0000, 1'b0, 32'h0);
        probe("other_set", 32'h0000_0040, 1'b1, 32'h0000_0100);

        // Flush while idle with a resident line requested.
        addr    = 32'h0000_0800;
        addr_en = 1'b1;
        flush   = 1'b1;
        #1;
        check("flush_idle_hm", hm(), 32'd1);
        addr_en = 1'b0;
        tick;
        flush = 1'b0;
        probe("post_flush_0040", 32'h0000_0040, 1'b0, 32'h0);
        fill(32'h0000_0800, 32'h0000_0500, 0, -1);

        // Flush at beat 3: burst drains, nothing installed, everything invalidated.
        fill(32'h0000_0060, 32'h0000_0600, 0, 3);
        probe("abort_no_hit", 32'h0000_0060, 1'b0, 32'h0);
        probe("abort_cleared", 32'h0000_0800, 1'b0, 32'h0);
        fill(32'h0000_0060, 32'h0000_0700, 0, -1);
        probe("refill_after_abort", 32'h0000_0064, 1'b1, 32'h0000_0701);

        // arready stall of 10 cycles with stray beats.
        fill(32'h0000_0080, 32'h0000_0800, 10, -1);
        probe("stall_word7", 32'h0000_009C, 1'b1, 32'h0000_0807);

        // Reset asserted at beat 4 of a refill.
        addr    = 32'h0000_00A0;
        addr_en = 1'b1;
        #1;
        check("rst_test_miss", hm(), 32'd1);
        tick;
        axi_arready = 1'b1;
        tick;
        axi_arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            axi_rvalid = 1'b1;
            axi_rdata  = 32'h0000_0900 + k;
            tick;
        end
        axi_rdata = 32'h0000_0904;
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_hit_miss", hm(), 32'd0);
        check("midrst_arvalid", {31'd0, axi_arvalid}, 32'd0);
        check("midrst_araddr", axi_araddr, 32'd0);
        check("midrst_inst", inst_o, 32'd0);
        axi_rvalid = 1'b0;
        addr_en    = 1'b0;
        tick;
        resetn = 1'b1;
        tick;
        probe("post_rst_0060", 32'h0000_0060, 1'b0, 32'h0);
        probe("post_rst_0080", 32'h0000_0080, 1'b0, 32'h0);
        probe("post_rst_00a0", 32'h0000_00A0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
